// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : Bundle of the two master ports (A, B) and the single-port RAM
//            pins that sit around ram_port_arbiter.
//            slave  - arbiter side
//            master - requester side (drives req/we/addr/wdata)
//            ram    - RAM side (drives ram_data_out)
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16
);
  localparam int C_AW = $clog2(RAM_DEPTH);

  // Master A
  logic                  a_req;
  logic                  a_we;
  logic [C_AW-1:0]       a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  // Master B
  logic                  b_req;
  logic                  b_we;
  logic [C_AW-1:0]       b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  // RAM pins
  logic                  ram_cs;
  logic                  ram_oe;
  logic                  ram_wr_en;
  logic [C_AW-1:0]       ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_data_out,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_cs, ram_oe, ram_wr_en, ram_addr, ram_data_in
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport ram (
    input  ram_cs, ram_oe, ram_wr_en, ram_addr, ram_data_in,
    output ram_data_out
  );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares one single-address-port RAM between two masters (A, B).
//            Commands are serialised onto registered RAM pins through a
//            three-state FSM (IDLE -> CMD [-> RESP]) and read data is routed
//            back to the issuing master.
//            Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority
//            (A always wins a tie, no last-served pointer); default build is
//            round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus
);

  localparam int C_AW = $clog2(RAM_DEPTH);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CMD  = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  // FSM and transaction bookkeeping
  logic [1:0]            r_state;
  logic                  r_win_b;     // 1: current transaction belongs to B
  logic                  r_win_we;    // 1: current transaction is a write

  // Registered master-side outputs
  logic                  r_a_gnt;
  logic                  r_b_gnt;
  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  // Registered RAM pins
  logic                  r_ram_cs;
  logic                  r_ram_oe;
  logic                  r_ram_wr_en;
  logic [C_AW-1:0]       r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data_in;

  // Arbitration wires
  logic                  w_any_req;
  logic                  w_accept;
  logic                  w_pick_b;
  logic                  w_sel_we;
  logic [C_AW-1:0]       w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // Requests are only looked at while IDLE; anything held in CMD/RESP waits.
  assign w_any_req = bus.a_req | bus.b_req;
  assign w_accept  = (r_state == C_IDLE) && w_any_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // A wins whenever it asks; B only gets through when A is quiet.
  assign w_pick_b = ~bus.a_req;
`else
  // Last-served pointer: 1 = B was served last. Resetting to B lets A win
  // the first tie.
  logic r_last_b;

  // Pointer moves only when a grant is actually issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (w_accept) begin
      r_last_b <= w_pick_b;
    end
  end

  // Single requester wins outright; on a tie the port not served last wins.
  assign w_pick_b = (bus.a_req && bus.b_req) ? ~r_last_b : bus.b_req;
`endif

  // Winner's command, muxed in front of the RAM pin registers.
  assign w_sel_we    = w_pick_b ? bus.b_we    : bus.a_we;
  assign w_sel_addr  = w_pick_b ? bus.b_addr  : bus.a_addr;
  assign w_sel_wdata = w_pick_b ? bus.b_wdata : bus.a_wdata;

  // Sequencer: accept in IDLE, let the RAM execute in CMD, collect in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= C_IDLE;
      r_win_b  <= 1'b0;
      r_win_we <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_accept) begin
            r_state  <= C_CMD;
            r_win_b  <= w_pick_b;
            r_win_we <= w_sel_we;
          end
        end
        C_CMD: begin
          // Writes are complete once the RAM has taken this edge.
          r_state <= r_win_we ? C_IDLE : C_RESP;
        end
        C_RESP: begin
          r_state <= C_IDLE;
        end
        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  // One-cycle grant pulse to the winner on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
    end else begin
      r_a_gnt <= w_accept & ~w_pick_b;
      r_b_gnt <= w_accept &  w_pick_b;
    end
  end

  // RAM pins: controls are single-cycle strobes, address/data hold their
  // last value so the bus does not toggle while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_cs      <= 1'b0;
      r_ram_oe      <= 1'b0;
      r_ram_wr_en   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_ram_cs    <= 1'b0;
      r_ram_oe    <= 1'b0;
      r_ram_wr_en <= 1'b0;
      if (w_accept) begin
        r_ram_cs   <= 1'b1;
        r_ram_addr <= w_sel_addr;
        if (w_sel_we) begin
          r_ram_wr_en   <= 1'b1;
          r_ram_data_in <= w_sel_wdata;
        end else begin
          r_ram_oe <= 1'b1;
        end
      end
    end
  end

  // Read return: the RAM's registered output is valid in RESP; steer it to
  // the issuing port and hold it there until that port's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (r_state == C_RESP) begin
        if (r_win_b) begin
          r_b_rvalid <= 1'b1;
          r_b_rdata  <= bus.ram_data_out;
        end else begin
          r_a_rvalid <= 1'b1;
          r_a_rdata  <= bus.ram_data_out;
        end
      end
    end
  end

  assign bus.a_gnt       = r_a_gnt;
  assign bus.b_gnt       = r_b_gnt;
  assign bus.a_rvalid    = r_a_rvalid;
  assign bus.b_rvalid    = r_b_rvalid;
  assign bus.a_rdata     = r_a_rdata;
  assign bus.b_rdata     = r_b_rdata;
  assign bus.ram_cs      = r_ram_cs;
  assign bus.ram_oe      = r_ram_oe;
  assign bus.ram_wr_en   = r_ram_wr_en;
  assign bus.ram_addr    = r_ram_addr;
  assign bus.ram_data_in = r_ram_data_in;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with a
//            behavioural registered-output RAM. Honours RAM_ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int C_DW    = 8;
  localparam int C_DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(C_DW), .RAM_DEPTH(C_DEPTH)) bus ();

  ram_port_arbiter #(.DATA_WIDTH(C_DW), .RAM_DEPTH(C_DEPTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural RAM: write and registered read on the rising edge with cs.
  logic [C_DW-1:0] r_mem [C_DEPTH];
  logic [C_DW-1:0] r_dout     = '0;
  logic            r_mem_init = 1'b0;

  always @(posedge clk) begin
    if (!r_mem_init) begin
      for (int i = 0; i < C_DEPTH; i++) r_mem[i] <= '0;
      r_mem_init <= 1'b1;
    end else if (bus.ram_cs) begin
      if (bus.ram_wr_en)   r_mem[bus.ram_addr] <= bus.ram_data_in;
      else if (bus.ram_oe) r_dout <= r_mem[bus.ram_addr];
    end
  end

  assign bus.ram_data_out = r_dout;

  // Event counters, sampled mid-cycle.
  int a_g_cnt = 0, b_g_cnt = 0, a_rv_cnt = 0, b_rv_cnt = 0;
  int acc_cnt = 0, clash_cnt = 0;

  always @(negedge clk) begin
    if (bus.a_gnt)    a_g_cnt++;
    if (bus.b_gnt)    b_g_cnt++;
    if (bus.a_rvalid) a_rv_cnt++;
    if (bus.b_rvalid) b_rv_cnt++;
    if (bus.ram_cs)   acc_cnt++;
    if ((bus.a_gnt | bus.b_gnt) & (bus.a_rvalid | bus.b_rvalid)) clash_cnt++;
    if (bus.a_gnt & bus.b_gnt) clash_cnt++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the falling edge (monitors have already run).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Raise a request, wait (bounded) for its grant, then drop it.
  task automatic issue(input bit port_b, input bit we, input logic [3:0] addr,
                       input logic [7:0] data);
    bit seen;
    seen = 1'b0;
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (port_b ? bus.b_gnt : bus.a_gnt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("issue_gnt_timeout", 32'd0, 32'd1);
    if (port_b) bus.b_req = 1'b0;
    else        bus.a_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  snap_ag, snap_bg, snap_arv, snap_brv, snap_acc;
    bit  exp_b;
    bit  first_seen, first_b, a_got;
    logic [7:0] a_data;
    logic [1:0] exp_g;

    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd1; bus.a_wdata = '0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd2; bus.b_wdata = '0;

    // ---------------- Reset with both requests pending ----------------
    rst_n = 1'b0;
    repeat (4) tick();
    check_eq("rst_gnt",     {bus.a_gnt, bus.b_gnt}, 2'b00);
    check_eq("rst_rvalid",  {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    check_eq("rst_ram_ctl", {bus.ram_cs, bus.ram_wr_en, bus.ram_oe}, 3'b000);
    check_eq("rst_ram_addr", bus.ram_addr, 4'h0);
    check_eq("rst_ram_din",  bus.ram_data_in, 8'h00);
    check_eq("rst_rdata",   {bus.a_rdata, bus.b_rdata}, 16'h0000);
    check_eq("rst_gnt_cnt", a_g_cnt + b_g_cnt, 0);
    rst_n = 1'b1;
    tick();
    check_eq("first_tie_to_a", {bus.a_gnt, bus.b_gnt}, 2'b10);
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    repeat (3) tick();

    // ---------------- Single write then read ----------------
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd3; bus.a_wdata = 8'hA5;
    tick();
    check_eq("wr_gnt",      {bus.a_gnt, bus.b_gnt}, 2'b10);
    check_eq("wr_ram_ctl",  {bus.ram_cs, bus.ram_wr_en, bus.ram_oe}, 3'b110);
    check_eq("wr_ram_addr", bus.ram_addr, 4'd3);
    check_eq("wr_ram_din",  bus.ram_data_in, 8'hA5);
    bus.a_req = 1'b0;
    tick();
    check_eq("wr_ctl_drop", {bus.ram_cs, bus.ram_wr_en, bus.a_gnt}, 3'b000);
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    tick();
    check_eq("rd_accept", {bus.a_gnt, bus.ram_cs, bus.ram_wr_en, bus.ram_oe}, 4'b1101);
    bus.a_req = 1'b0;
    tick();
    check_eq("rd_not_early", bus.a_rvalid, 1'b0);
    tick();
    check_eq("rd_rvalid", bus.a_rvalid, 1'b1);
    check_eq("rd_rdata",  bus.a_rdata, 8'hA5);
    tick();
    check_eq("rd_rvalid_pulse", bus.a_rvalid, 1'b0);
    check_eq("rd_rdata_hold",   bus.a_rdata, 8'hA5);

    // ---------------- Preload; B served last ----------------
    issue(1'b0, 1'b1, 4'd1,  8'h11);
    issue(1'b1, 1'b1, 4'd15, 8'h5A);
    issue(1'b1, 1'b1, 4'd2,  8'h22);
    tick();

    // ---------------- Contention: both read continuously ----------------
    snap_bg = b_g_cnt;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd1;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd2;
    for (int i = 1; i <= 12; i++) begin
      tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_b = 1'b0;
`else
      exp_b = (((i - 1) / 3) % 2) == 1;
`endif
      exp_g = 2'b00;
      if (i % 3 == 1) exp_g = exp_b ? 2'b01 : 2'b10;
      check_eq($sformatf("cont_gnt_c%0d", i), {bus.a_gnt, bus.b_gnt}, exp_g);
      if (i % 3 == 0) begin
        check_eq($sformatf("cont_rv_c%0d", i), {bus.a_rvalid, bus.b_rvalid},
                 exp_b ? 2'b01 : 2'b10);
        check_eq($sformatf("cont_data_c%0d", i),
                 exp_b ? bus.b_rdata : bus.a_rdata, exp_b ? 8'h22 : 8'h11);
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    check_eq("cont_b_gnt_cnt", b_g_cnt - snap_bg, 0);
`else
    check_eq("cont_b_gnt_cnt", b_g_cnt - snap_bg, 2);
`endif
    tick();

    // ---------------- Mixed: B write vs A read, same address ----------------
    issue(1'b0, 1'b1, 4'd5, 8'h00);   // A served last
    tick();
    snap_ag = a_g_cnt; snap_bg = b_g_cnt; snap_arv = a_rv_cnt; snap_brv = b_rv_cnt;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd5;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd5; bus.b_wdata = 8'h3C;
    first_seen = 1'b0; first_b = 1'b0; a_got = 1'b0; a_data = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!first_seen && (bus.a_gnt || bus.b_gnt)) begin
        first_seen = 1'b1;
        first_b    = bus.b_gnt;
      end
      if (bus.a_gnt) bus.a_req = 1'b0;
      if (bus.b_gnt) bus.b_req = 1'b0;
      if (bus.a_rvalid) begin
        a_got  = 1'b1;
        a_data = bus.a_rdata;
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    check_eq("mix_first_b", first_b, 1'b0);
    check_eq("mix_a_data",  a_data, 8'h00);
`else
    check_eq("mix_first_b", first_b, 1'b1);
    check_eq("mix_a_data",  a_data, 8'h3C);
`endif
    check_eq("mix_a_got",    a_got, 1'b1);
    check_eq("mix_gnt_cnt",  {8'(a_g_cnt - snap_ag), 8'(b_g_cnt - snap_bg)}, 16'h0101);
    check_eq("mix_a_rv_cnt", a_rv_cnt - snap_arv, 1);
    check_eq("mix_b_rv_cnt", b_rv_cnt - snap_brv, 0);

    // ---------------- Reset during RESP ----------------
    issue(1'b0, 1'b0, 4'd1, 8'h00);
    snap_arv = a_rv_cnt;
    tick();                            // now in RESP
    rst_n = 1'b0;
    #1;
    check_eq("rstresp_rvalid", bus.a_rvalid, 1'b0);
    check_eq("rstresp_rdata",  bus.a_rdata, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rstresp_no_rv", a_rv_cnt - snap_arv, 0);
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd9; bus.b_wdata = 8'h77;
    tick();
    check_eq("rstresp_idle_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
    bus.b_req = 1'b0;
    tick();

    // ---------------- Withdrawn B request during A read of top address ----------------
    issue(1'b0, 1'b0, 4'd15, 8'h00);
    snap_bg = b_g_cnt; snap_acc = acc_cnt;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd7; bus.b_wdata = 8'hFF;
    tick();
    bus.b_req = 1'b0;
    tick();
    check_eq("wd_a_rvalid", bus.a_rvalid, 1'b1);
    check_eq("wd_a_rdata",  bus.a_rdata, 8'h5A);
    repeat (3) tick();
    check_eq("wd_b_gnt_cnt", b_g_cnt - snap_bg, 0);
    check_eq("wd_ram_acc",   acc_cnt - snap_acc, 0);

    check_eq("gnt_rvalid_clash", clash_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single-address-port RAM between two independent masters (A and B). It serialises read and write commands onto the RAM's cs/oe/wr_en/addr/data_in pins and routes the registered read data back to the issuing master. Arbitration is round-robin by default. The block sits directly in front of the RAM, and the masters never drive the RAM themselves.

## Interface
- Data_Width, 8, data bus width; must match the RAM.
- RAM_Depth, 16, RAM word count; address width AW = $clog2(RAM_Depth).

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  master requests an access; held until its gnt is seen.
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_addr / b_addr  in  AW  word address.
- a_wdata / b_wdata  in  Data_Width  write data.
- a_gnt / b_gnt  out  1  one-cycle pulse: request accepted; master may change req/we/addr/wdata at the next edge.
- a_rvalid / b_rvalid  out  1  one-cycle pulse: read data valid.
- a_rdata / b_rdata  out  Data_Width  read data, held until the next rvalid to that port.
- ram_cs, ram_oe, ram_wr_en  out  1  RAM controls, all registered.
- ram_addr  out  AW  RAM address, registered.
- ram_data_in  out  Data_Width  RAM write data, registered.
- ram_data_out  in  Data_Width  RAM registered read data.

## Operation
- FSM states are IDLE, CMD and RESP.
- IDLE: if no req is sampled, stay in IDLE with ram_cs=0. If any req is sampled, pick a winner, register the winner's command onto the ram_* outputs, pulse the winner's gnt, remember the winner and we, and go to CMD.
  - ram_cs=1 and ram_addr=addr for both reads and writes.
  - Write: ram_wr_en=1, ram_oe=0, ram_data_in=wdata.
  - Read: ram_wr_en=0, ram_oe=1.
- CMD: the RAM executes on this edge. Drop ram_cs, ram_wr_en and ram_oe to 0. Go to RESP on a read, or to IDLE on a write.
- RESP: capture ram_data_out into the winner's rdata, pulse the winner's rvalid, and go to IDLE.
- Requests are never sampled in CMD or RESP. A req held during these states waits.
- Round-robin winner selection:
  - If only one req is high, that port wins.
  - If both are high, the port not served last wins.
  - The last-served pointer updates only on a grant. It resets to B, so A wins the first tie.
- A grant pulse and an rvalid pulse never occur in the same cycle, because IDLE is never concurrent with RESP.
- Address width is exactly AW. There is no wrap logic; out-of-range addresses are not possible by width.

## Timing
- Reset values: every output is 0, including a_rdata, b_rdata, ram_addr and ram_data_in. The FSM resets to IDLE and the pointer resets to B.
- Write: req sampled at edge k gives gnt high for cycle k..k+1 and ram_cs/ram_wr_en high for the same cycle. The RAM writes at edge k+1.
- Read: req sampled at edge k, the RAM loads data_out at edge k+1, and rvalid/rdata are set at edge k+2. Read latency is 2 cycles from the sampling edge.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- The earliest next acceptance is edge k+2 after a write and edge k+3 after a read.
- Reset mid-operation: asserting rst_n low aborts immediately.
  - A read in CMD or RESP produces no rvalid.
  - A write in CMD may or may not land, depending on whether the RAM's edge occurs before reset.
  - The master must reissue after reset.
- A req that drops before its gnt is withdrawn. No gnt is issued for it.

## Configuration
- RAM_ARB_FIXED_PRIO_EN
  - Defined: port A always wins when both req are high. B is served only when A is idle, and B may starve. The pointer register is not built.
  - Undefined (default): round-robin as described above, which guarantees each port waits at most one foreign access.

## Test plan
- Reset: hold rst_n=0 with both req=1. All outputs stay 0 and no gnt is issued. Release reset, and the first grant goes to A.
- Single write then read: A writes addr 3 = 0xA5. a_gnt pulses and ram_cs/ram_wr_en are high for 1 cycle. A then reads addr 3, and a_rvalid pulses with a_rdata=0xA5 exactly 2 cycles after the sampling edge.
- Contention: A and B both hold read requests continuously (A addr 1 = 0x11, B addr 2 = 0x22).
  - Default build: grants alternate A, B, A, B at 3-cycle spacing with correct data per port.
  - RAM_ARB_FIXED_PRIO_EN build: A is granted every 3 cycles and b_gnt is never asserted.
- Mixed: B writes addr 5 = 0x3C while A is pending a read of addr 5. If B is served first, A returns 0x3C. b_rvalid never pulses for a write.
- Reset during RESP: start an A read, then pull rst_n low in the RESP cycle. a_rvalid stays 0, a_rdata is 0, and the FSM is in IDLE after release.
- Withdrawn request: b_req is high for 1 cycle while A is being served (FSM not in IDLE). b_gnt never pulses and the RAM sees no B access.
